// File: rtl/inv_sweep_checker.sv
// inv_sweep_checker
// Exhaustive self-test sequencer for a WIDTH-bit inverter. One sweep
// presents every value 0 .. 2^WIDTH-1 on stim in ascending order, one per
// cycle. Each cycle it compares the inverter output resp with ~stim. It
// tallies mismatches and captures the first failing stimulus.
//
// Ports
//   clk              : single clock, all state changes on its rising edge
//   rst              : synchronous, active-high reset (wins over start)
//   start            : begin a sweep; only honoured in IDLE or DONE
//   stim             : registered stimulus driven to the inverter input
//   resp             : inverter output, combinational from stim
//   busy             : sweep in progress (high for exactly 2^WIDTH cycles)
//   done             : sweep finished; held until the next start or rst
//   pass             : valid with done; 1 when the sweep saw no mismatch
//   err_count        : mismatch count of the current or last sweep
//   first_fail       : stim value of the first mismatch in the sweep
//   first_fail_valid : first_fail holds a captured value
module inv_sweep_checker #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] stim,
  input  logic [WIDTH-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_count,
  output logic [WIDTH-1:0] first_fail,
  output logic             first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STIM_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] STIM_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ERR_ZERO  = {(WIDTH+1){1'b0}};

  state_t           state_r, state_s;
  logic [WIDTH-1:0] stim_r, stim_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             pass_r, pass_s;
  logic [WIDTH:0]   err_count_r, err_count_s;
  logic [WIDTH-1:0] first_fail_r, first_fail_s;
  logic             first_fail_valid_r, first_fail_valid_s;

  logic             mismatch_s;
  logic [WIDTH:0]   err_inc_s;

  // The vector under test fails when the response is not the exact inverse.
  // err_inc_s is the count including this vector; the final verdict uses it.
  assign mismatch_s = (resp != ~stim_r);
  assign err_inc_s  = err_count_r + {{WIDTH{1'b0}}, mismatch_s};

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_s            = state_r;
    stim_s             = stim_r;
    busy_s             = busy_r;
    done_s             = done_r;
    pass_s             = pass_r;
    err_count_s        = err_count_r;
    first_fail_s       = first_fail_r;
    first_fail_valid_s = first_fail_valid_r;

    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s            = RUN;
          stim_s             = STIM_ZERO;
          busy_s             = 1'b1;
          done_s             = 1'b0;
          pass_s             = 1'b0;
          err_count_s        = ERR_ZERO;
          first_fail_s       = STIM_ZERO;
          first_fail_valid_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      RUN: begin
        err_count_s = err_inc_s;
        // Only the earliest failing vector is recorded.
        if (mismatch_s && !first_fail_valid_r) begin
          first_fail_s       = stim_r;
          first_fail_valid_s = 1'b1;
        end else begin
          first_fail_s       = first_fail_r;
          first_fail_valid_s = first_fail_valid_r;
        end
        // The all-ones vector is checked on the same edge that ends the sweep.
        if (stim_r == ALL_ONES) begin
          state_s = DONE;
          stim_s  = STIM_ZERO;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          pass_s  = (err_inc_s == ERR_ZERO);
        end else begin
          stim_s  = stim_r + STIM_ONE;
        end
      end

      default: begin
        state_s            = IDLE;
        stim_s             = STIM_ZERO;
        busy_s             = 1'b0;
        done_s             = 1'b0;
        pass_s             = 1'b0;
        err_count_s        = ERR_ZERO;
        first_fail_s       = STIM_ZERO;
        first_fail_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; rst clears everything, including a sweep in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= IDLE;
      stim_r             <= STIM_ZERO;
      busy_r             <= 1'b0;
      done_r             <= 1'b0;
      pass_r             <= 1'b0;
      err_count_r        <= ERR_ZERO;
      first_fail_r       <= STIM_ZERO;
      first_fail_valid_r <= 1'b0;
    end else begin
      state_r            <= state_s;
      stim_r             <= stim_s;
      busy_r             <= busy_s;
      done_r             <= done_s;
      pass_r             <= pass_s;
      err_count_r        <= err_count_s;
      first_fail_r       <= first_fail_s;
      first_fail_valid_r <= first_fail_valid_s;
    end
  end

  assign stim             = stim_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign err_count        = err_count_r;
  assign first_fail       = first_fail_r;
  assign first_fail_valid = first_fail_valid_r;

endmodule

// File: tb/tb_inv_sweep_checker.sv
// Testbench for inv_sweep_checker. There are three instances: WIDTH=10 for
// fault scenarios, WIDTH=4 for back-to-back sweeps and WIDTH=16 for one full
// default-width sweep. Expected results come from a whole-sweep reference
// model that enumerates every stimulus value and applies the inverter rule.
module tb_inv_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=10 instance, driven through a configurable faulty inverter
  logic        start10, busy10, done10, pass10, ffv10;
  logic [9:0]  stim10, resp10, ff10;
  logic [10:0] err10;

  // WIDTH=4 instance, correct inverter
  logic        start4, busy4, done4, pass4, ffv4;
  logic [3:0]  stim4, resp4, ff4;
  logic [4:0]  err4;

  // WIDTH=16 instance, correct inverter
  logic        start16, busy16, done16, pass16, ffv16;
  logic [15:0] stim16, resp16, ff16;
  logic [16:0] err16;

  int vectors     = 0;
  int miscompares = 0;

  // fault model for the 10-bit inverter
  int         mode;   // 0 good, 1 stuck-at-0, 2 single bad vector, 3 periodic
  int         fbit;
  logic [9:0] badv;
  logic [9:0] xmask;
  int         modv;
  int         remv;

  inv_sweep_checker #(.WIDTH(10)) dut10 (
    .clk(clk), .rst(rst), .start(start10), .stim(stim10), .resp(resp10),
    .busy(busy10), .done(done10), .pass(pass10), .err_count(err10),
    .first_fail(ff10), .first_fail_valid(ffv10));

  inv_sweep_checker #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .stim(stim4), .resp(resp4),
    .busy(busy4), .done(done4), .pass(pass4), .err_count(err4),
    .first_fail(ff4), .first_fail_valid(ffv4));

  inv_sweep_checker #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .stim(stim16), .resp(resp16),
    .busy(busy16), .done(done16), .pass(pass16), .err_count(err16),
    .first_fail(ff16), .first_fail_valid(ffv16));

  function automatic logic [9:0] fault10(input logic [9:0] s);
    case (mode)
      0:       return ~s;
      1:       return (~s) & ~(10'd1 << fbit);
      2:       return (s == badv) ? (~s ^ xmask) : ~s;
      default: return ((int'(s) % modv) == remv) ? (~s ^ xmask) : ~s;
    endcase
  endfunction

  always @(stim10 or mode or fbit or badv or xmask or modv or remv)
    resp10 = fault10(stim10);
  assign resp4  = ~stim4;
  assign resp16 = ~stim16;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // whole-sweep reference: mismatch count and first failing value
  task automatic model10(output int cnt, output int first, output bit has);
    logic [9:0] v;
    cnt = 0; first = 0; has = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      v = 10'(i);
      if (fault10(v) !== ~v) begin
        if (!has) begin first = i; has = 1'b1; end
        cnt++;
      end
    end
  endtask

  task automatic run_sweep10(input string tag, input bit rand_start);
    int cnt, first, cyc, running;
    bit has, order_ok, run_ok;
    model10(cnt, first, has);
    @(negedge clk) start10 = 1'b1;
    @(negedge clk) start10 = 1'b0;
    chk({tag, "_busy0"}, {31'd0, busy10}, 32'd1);
    chk({tag, "_stim0"}, {22'd0, stim10}, 32'd0);
    chk({tag, "_done0"}, {31'd0, done10}, 32'd0);
    chk({tag, "_err0"},  {21'd0, err10},  32'd0);
    chk({tag, "_ffv0"},  {31'd0, ffv10},  32'd0);
    cyc = 0; running = 0; order_ok = 1'b1; run_ok = 1'b1;
    while (busy10 === 1'b1 && cyc < 1100) begin
      if (stim10 !== 10'(cyc)) order_ok = 1'b0;
      if (err10 !== 11'(running)) run_ok = 1'b0;
      if (fault10(10'(cyc)) !== ~10'(cyc)) running++;
      cyc++;
      start10 = rand_start ? 1'($urandom_range(1, 0)) : 1'b0;
      @(negedge clk);
    end
    start10 = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(cyc), 32'd1024);
    chk({tag, "_stim_order"}, {31'd0, order_ok}, 32'd1);
    chk({tag, "_running_err"}, {31'd0, run_ok}, 32'd1);
    chk({tag, "_done"}, {31'd0, done10}, 32'd1);
    chk({tag, "_pass"}, {31'd0, pass10}, {31'd0, (cnt == 0)});
    chk({tag, "_err"}, {21'd0, err10}, 32'(cnt));
    chk({tag, "_ffv"}, {31'd0, ffv10}, {31'd0, has});
    chk({tag, "_ff"}, {22'd0, ff10}, 32'(first));
    chk({tag, "_stim_end"}, {22'd0, stim10}, 32'd0);
    repeat (3) @(negedge clk);
    chk({tag, "_hold_done"}, {31'd0, done10}, 32'd1);
    chk({tag, "_hold_err"}, {21'd0, err10}, 32'(cnt));
    chk({tag, "_hold_ff"}, {22'd0, ff10}, 32'(first));
  endtask

  initial begin
    int cyc;
    bit saw_done;
    logic [15:0] last16;

    mode = 0; fbit = 0; badv = 10'd0; xmask = 10'd1; modv = 2; remv = 0;
    rst = 1'b1; start10 = 1'b0; start4 = 1'b0; start16 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // reset state
    chk("rst_stim", {22'd0, stim10}, 32'd0);
    chk("rst_busy", {31'd0, busy10}, 32'd0);
    chk("rst_done", {31'd0, done10}, 32'd0);
    chk("rst_pass", {31'd0, pass10}, 32'd0);
    chk("rst_err",  {21'd0, err10},  32'd0);
    chk("rst_ff",   {22'd0, ff10},   32'd0);
    chk("rst_ffv",  {31'd0, ffv10},  32'd0);

    // rst wins over start at the same edge
    rst = 1'b1; start10 = 1'b1;
    @(negedge clk);
    chk("prio_busy", {31'd0, busy10}, 32'd0);
    rst = 1'b0; start10 = 1'b0;
    @(negedge clk);
    chk("prio_busy_after", {31'd0, busy10}, 32'd0);

    // good inverter, with random start pulses during the run
    mode = 0;
    run_sweep10("good", 1'b1);

    // stuck-at-0 on a random response bit
    mode = 1; fbit = $urandom_range(9, 0);
    run_sweep10("stuck", 1'b1);
    chk("stuck_err_half", {21'd0, err10}, 32'd512);
    chk("stuck_ff_zero", {22'd0, ff10}, 32'd0);

    // single bad vector at a random value
    mode = 2; badv = 10'($urandom_range(1022, 1)); xmask = 10'($urandom_range(1023, 1));
    run_sweep10("single", 1'b0);

    // single bad vector on the very last stimulus
    badv = 10'h3FF;
    run_sweep10("last", 1'b0);

    // single bad vector on the very first stimulus
    badv = 10'h000;
    run_sweep10("first", 1'b0);

    // periodic random fault pattern
    mode = 3; modv = $urandom_range(7, 2); remv = $urandom_range(modv - 1, 0);
    xmask = 10'($urandom_range(1023, 1));
    run_sweep10("periodic", 1'b1);

    // reset in the middle of a sweep at stim=0x100
    mode = 0;
    @(negedge clk) start10 = 1'b1;
    @(negedge clk) start10 = 1'b0;
    cyc = 0;
    while (stim10 !== 10'h100 && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    chk("mid_reach_100", {22'd0, stim10}, 32'h100);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    chk("mid_stim", {22'd0, stim10}, 32'd0);
    chk("mid_busy", {31'd0, busy10}, 32'd0);
    chk("mid_done", {31'd0, done10}, 32'd0);
    chk("mid_err",  {21'd0, err10},  32'd0);
    chk("mid_ffv",  {31'd0, ffv10},  32'd0);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done10 === 1'b1 || busy10 === 1'b1) saw_done = 1'b1;
    end
    chk("mid_quiet", {31'd0, saw_done}, 32'd0);

    // WIDTH=4, start held high across DONE
    @(negedge clk) start4 = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (busy4 === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("w4_busy_cycles", 32'(cyc), 32'd16);
    chk("w4_done", {31'd0, done4}, 32'd1);
    chk("w4_pass", {31'd0, pass4}, 32'd1);
    @(negedge clk);
    chk("w4_rerun_busy", {31'd0, busy4}, 32'd1);
    chk("w4_rerun_done", {31'd0, done4}, 32'd0);
    chk("w4_rerun_stim", {28'd0, stim4}, 32'd0);
    start4 = 1'b0;
    cyc = 0;
    while (busy4 === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge clk);
    end
    chk("w4_second_cycles", 32'(cyc), 32'd16);
    chk("w4_second_pass", {31'd0, pass4}, 32'd1);

    // WIDTH=16, full default-width sweep with a good inverter
    @(negedge clk) start16 = 1'b1;
    @(negedge clk) start16 = 1'b0;
    cyc = 0; last16 = 16'd0;
    while (busy16 === 1'b1 && cyc < 70000) begin
      last16 = stim16;
      cyc++;
      @(negedge clk);
    end
    chk("w16_busy_cycles", 32'(cyc), 32'd65536);
    chk("w16_last_stim", {16'd0, last16}, 32'hFFFF);
    chk("w16_done", {31'd0, done16}, 32'd1);
    chk("w16_pass", {31'd0, pass16}, 32'd1);
    chk("w16_err", {15'd0, err16}, 32'd0);
    chk("w16_ffv", {31'd0, ffv16}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_sweep_checker.md
INV_SWEEP_CHECKER -- requirements
Module: inv_sweep_checker

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the vector width of the inverter under test.
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit: synchronous, active-high reset.
REQ-004 Port start SHALL be input, 1 bit: request a full sweep, sampled in IDLE or DONE only.
REQ-005 Port stim SHALL be output, WIDTH bits: registered stimulus driven to the DUT input a.
REQ-006 Port resp SHALL be input, WIDTH bits: DUT output y, combinational from stim, valid in the same cycle.
REQ-007 Port busy SHALL be output, 1 bit: sweep in progress.
REQ-008 Port done SHALL be output, 1 bit: sweep complete; a level held until the next sweep starts or reset.
REQ-009 Port pass SHALL be output, 1 bit: valid while done=1; 1 means zero mismatches.
REQ-010 Port err_count SHALL be output, WIDTH+1 bits: number of mismatching vectors in the current or last sweep.
REQ-011 Port first_fail SHALL be output, WIDTH bits: stim value of the first mismatch.
REQ-012 Port first_fail_valid SHALL be output, 1 bit: first_fail holds a captured value.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-014 In IDLE or DONE, start=1 at edge t SHALL put the FSM in RUN at t+1, with the following values:
- stim=0, busy=1, done=0, pass=0
- err_count=0, first_fail=0, first_fail_valid=0
REQ-015 In RUN, every edge SHALL compare resp against bitwise NOT of stim, one vector per cycle, with no gaps.
REQ-016 A mismatch SHALL increment err_count by 1.
REQ-017 On the first mismatch of a sweep, first_fail SHALL be loaded with stim and first_fail_valid set to 1; later mismatches SHALL NOT change them.
REQ-018 In RUN with stim != all-ones, stim SHALL increment by 1 each edge.
REQ-019 In RUN with stim = all-ones, the check SHALL complete and, at the same edge, the FSM SHALL enter DONE with:
- busy=0, done=1, stim=0
- pass=1 iff the final err_count (including this vector) is 0
REQ-020 busy SHALL be high for exactly 2^WIDTH consecutive cycles per sweep.
REQ-021 stim SHALL wrap-free cover 0 to 2^WIDTH-1 exactly once, in ascending order.
REQ-022 err_count SHALL NOT overflow: its maximum value, 2^WIDTH, fits in WIDTH+1 bits.
REQ-023 start SHALL be ignored while in RUN.
REQ-024 start held high across DONE SHALL immediately begin a new sweep.
REQ-025 In DONE, all result outputs SHALL hold stable until start or rst.
REQ-026 All outputs SHALL be registered; no combinational path from resp or start to any output.

Reset
REQ-027 rst=1 at an edge SHALL force, at the next cycle, regardless of state or start:
- state IDLE
- stim=0, busy=0, done=0, pass=0
- err_count=0, first_fail=0, first_fail_valid=0
REQ-028 rst asserted mid-sweep SHALL abort the sweep, discard partial results, and not assert done.
REQ-029 rst SHALL take priority over start when both are asserted at the same edge.

Verification
REQ-030 Reset: after rst, all outputs are 0 and state is IDLE; start pulse -> busy=1, stim=0x0000 next cycle.
REQ-031 Correct DUT (resp=~stim), WIDTH=16:
- start pulse -> busy high 65536 cycles, stim ends at 0xFFFF
- then done=1, pass=1, err_count=0, first_fail_valid=0
REQ-032 Stuck-at-0 on resp[0]:
- err_count=32768, first_fail=0x0000, first_fail_valid=1, pass=0
REQ-033 Single bad vector (resp wrong only when stim=0x1234):
- err_count=1, first_fail=0x1234, pass=0
REQ-034 Mid-run events:
- start pulses during RUN -> no effect on stim sequence
- rst at stim=0x0100 -> all outputs 0 next cycle, done never asserted
REQ-035 WIDTH=4, correct DUT:
- busy exactly 16 cycles, then done=1, pass=1
- start held high -> second sweep begins the cycle after done rises and clears done
